// File: rtl/sc_statemachine_levelctrl_if.sv
// Game-control interface for the level controller: the four active-low
// player/datapath inputs and the control outputs back to the datapath.
interface sc_statemachine_levelctrl_if #(
  parameter int LEVEL_WIDTH = 3,
  parameter int LIVES_WIDTH = 2
);
  logic                   SC_STATEMACHINE_LEVELCTRL_startButton_InLow;
  logic                   SC_STATEMACHINE_LEVELCTRL_levelDone_InLow;
  logic                   SC_STATEMACHINE_LEVELCTRL_lifeLost_InLow;
  logic                   SC_STATEMACHINE_LEVELCTRL_pause_InLow;
  logic                   SC_STATEMACHINE_LEVELCTRL_clear_OutLow;
  logic                   SC_STATEMACHINE_LEVELCTRL_load_OutLow;
  logic                   SC_STATEMACHINE_LEVELCTRL_changeLevel_OutLow;
  logic [LEVEL_WIDTH-1:0] SC_STATEMACHINE_LEVELCTRL_transition_OutBUS;
  logic [LEVEL_WIDTH-1:0] SC_STATEMACHINE_LEVELCTRL_level_OutBUS;
  logic [LIVES_WIDTH-1:0] SC_STATEMACHINE_LEVELCTRL_lives_OutBUS;
  logic                   SC_STATEMACHINE_LEVELCTRL_gameOver_OutLow;
  logic                   SC_STATEMACHINE_LEVELCTRL_win_OutLow;

  // Player / datapath side: drives the requests, observes the controls.
  modport master (
    output SC_STATEMACHINE_LEVELCTRL_startButton_InLow,
    output SC_STATEMACHINE_LEVELCTRL_levelDone_InLow,
    output SC_STATEMACHINE_LEVELCTRL_lifeLost_InLow,
    output SC_STATEMACHINE_LEVELCTRL_pause_InLow,
    input  SC_STATEMACHINE_LEVELCTRL_clear_OutLow,
    input  SC_STATEMACHINE_LEVELCTRL_load_OutLow,
    input  SC_STATEMACHINE_LEVELCTRL_changeLevel_OutLow,
    input  SC_STATEMACHINE_LEVELCTRL_transition_OutBUS,
    input  SC_STATEMACHINE_LEVELCTRL_level_OutBUS,
    input  SC_STATEMACHINE_LEVELCTRL_lives_OutBUS,
    input  SC_STATEMACHINE_LEVELCTRL_gameOver_OutLow,
    input  SC_STATEMACHINE_LEVELCTRL_win_OutLow
  );

  // Controller side.
  modport slave (
    input  SC_STATEMACHINE_LEVELCTRL_startButton_InLow,
    input  SC_STATEMACHINE_LEVELCTRL_levelDone_InLow,
    input  SC_STATEMACHINE_LEVELCTRL_lifeLost_InLow,
    input  SC_STATEMACHINE_LEVELCTRL_pause_InLow,
    output SC_STATEMACHINE_LEVELCTRL_clear_OutLow,
    output SC_STATEMACHINE_LEVELCTRL_load_OutLow,
    output SC_STATEMACHINE_LEVELCTRL_changeLevel_OutLow,
    output SC_STATEMACHINE_LEVELCTRL_transition_OutBUS,
    output SC_STATEMACHINE_LEVELCTRL_level_OutBUS,
    output SC_STATEMACHINE_LEVELCTRL_lives_OutBUS,
    output SC_STATEMACHINE_LEVELCTRL_gameOver_OutLow,
    output SC_STATEMACHINE_LEVELCTRL_win_OutLow
  );
endinterface

// File: rtl/sc_statemachine_levelctrl.sv
// Level/lives controller for a simple game: start-on-release, per-level
// transition dwell, level-done / life-lost / pause handling, win and game over.
module sc_statemachine_levelctrl #(
  parameter int NUM_LEVELS   = 4,
  parameter int LEVEL_WIDTH  = 3,
  parameter int LIVES        = 3,
  parameter int LIVES_WIDTH  = 2,
  parameter int TRANS_CYCLES = 1
) (
  input logic                        SC_STATEMACHINE_LEVELCTRL_CLOCK_50,
  input logic                        SC_STATEMACHINE_LEVELCTRL_RESET_InHigh,
  sc_statemachine_levelctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_START    = 4'd1,
    S_IDLE     = 4'd2,
    S_RELEASE  = 4'd3,
    S_INIT     = 4'd4,
    S_TRANS    = 4'd5,
    S_PLAY     = 4'd6,
    S_PAUSE    = 4'd7,
    S_GAMEOVER = 4'd8,
    S_WIN      = 4'd9
  } state_t;

  localparam logic [15:0]            DWELL_LAST = 16'(TRANS_CYCLES - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX  = LEVEL_WIDTH'(NUM_LEVELS);
  localparam logic [LIVES_WIDTH-1:0] LIVES_INIT = LIVES_WIDTH'(LIVES);

  logic clk;
  logic rst;
  logic start_n, done_n, life_n, pause_n;

  assign clk     = SC_STATEMACHINE_LEVELCTRL_CLOCK_50;
  assign rst     = SC_STATEMACHINE_LEVELCTRL_RESET_InHigh;
  assign start_n = bus.SC_STATEMACHINE_LEVELCTRL_startButton_InLow;
  assign done_n  = bus.SC_STATEMACHINE_LEVELCTRL_levelDone_InLow;
  assign life_n  = bus.SC_STATEMACHINE_LEVELCTRL_lifeLost_InLow;
  assign pause_n = bus.SC_STATEMACHINE_LEVELCTRL_pause_InLow;

  state_t                 state_q, state_d;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [LIVES_WIDTH-1:0] lives_q, lives_d;
  logic [15:0]            dwell_q, dwell_d;

  logic                   clear_n, load_n, change_n, over_n, win_n;
  logic [LEVEL_WIDTH-1:0] transition;

  // State, level, lives and dwell registers; reset forces RESET immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      level_q <= '0;
      lives_q <= LIVES_INIT;
      dwell_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational block.
      state_q <= state_d;
      level_q <= level_d;
      lives_q <= lives_d;
      dwell_q <= dwell_d;
    end
  end

  // Next-state, counter updates and outputs, all decoded from the current state.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    level_d    = level_q;
    lives_d    = lives_q;
    dwell_d    = dwell_q;
    clear_n    = 1'b1;
    load_n     = 1'b1;
    change_n   = 1'b1;
    over_n     = 1'b1;
    win_n      = 1'b1;
    transition = '0;

    case (state_q)
      S_RESET: state_d = S_START;

      S_START: begin
        load_n  = 1'b0;
        lives_d = LIVES_INIT;
        level_d = '0;
        state_d = S_IDLE;
      end

      S_IDLE:    if (!start_n) state_d = S_RELEASE;

      // The game begins when the button is let go, not when it is pressed.
      S_RELEASE: if (start_n) state_d = S_INIT;

      S_INIT: begin
        clear_n = 1'b0;
        level_d = LEVEL_WIDTH'(1);
        dwell_d = '0;
        state_d = S_TRANS;
      end

      S_TRANS: begin
        change_n   = 1'b0;
        transition = level_q;
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          state_d = S_PLAY;
        end else begin
          dwell_d = dwell_q + 16'd1;
        end
      end

      // Same-clock requests resolve as levelDone > lifeLost > pause.
      S_PLAY: begin
        if (!done_n) begin
          if (level_q < LEVEL_MAX) begin
            level_d = level_q + LEVEL_WIDTH'(1);
            dwell_d = '0;
            state_d = S_TRANS;
          end else begin
            state_d = S_WIN;
          end
        end else if (!life_n) begin
          if (lives_q > LIVES_WIDTH'(1)) begin
            lives_d = lives_q - LIVES_WIDTH'(1);
            dwell_d = '0;
            state_d = S_TRANS;
          end else begin
            lives_d = '0;
            state_d = S_GAMEOVER;
          end
        end else if (!pause_n) begin
          state_d = S_PAUSE;
        end
      end

      S_PAUSE: if (pause_n) state_d = S_PLAY;

      S_GAMEOVER: begin
        over_n     = 1'b0;
        transition = '1;
        if (!start_n) state_d = S_START;
      end

      S_WIN: begin
        win_n      = 1'b0;
        transition = '1;
        if (!start_n) state_d = S_START;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.SC_STATEMACHINE_LEVELCTRL_clear_OutLow       = clear_n;
  assign bus.SC_STATEMACHINE_LEVELCTRL_load_OutLow        = load_n;
  assign bus.SC_STATEMACHINE_LEVELCTRL_changeLevel_OutLow = change_n;
  assign bus.SC_STATEMACHINE_LEVELCTRL_transition_OutBUS  = transition;
  assign bus.SC_STATEMACHINE_LEVELCTRL_level_OutBUS       = level_q;
  assign bus.SC_STATEMACHINE_LEVELCTRL_lives_OutBUS       = lives_q;
  assign bus.SC_STATEMACHINE_LEVELCTRL_gameOver_OutLow    = over_n;
  assign bus.SC_STATEMACHINE_LEVELCTRL_win_OutLow         = win_n;

endmodule

// File: tb/tb_sc_statemachine_levelctrl.sv
// Bench for sc_statemachine_levelctrl: two instances (defaults, and
// NUM_LEVELS=6 / TRANS_CYCLES=5) share the player inputs, each with its own
// reset, and both are compared every cycle against a behavioural game model.
module tb_sc_statemachine_levelctrl;

  localparam int NL0 = 4, TC0 = 1;
  localparam int NL1 = 6, TC1 = 5;
  localparam int LIVES = 3;

  // Game phases of the reference model.
  localparam int PH_RST = 0, PH_START = 1, PH_IDLE = 2, PH_REL = 3, PH_INIT = 4,
                 PH_TRANS = 5, PH_PLAY = 6, PH_PAUSE = 7, PH_OVER = 8, PH_WIN = 9;

  typedef struct {
    int ph;
    int level;
    int lives;
    int left;   // transition clocks still to run
  } mstate_t;

  typedef struct packed {
    logic       clear_n;
    logic       load_n;
    logic       chg_n;
    logic       over_n;
    logic       win_n;
    logic [2:0] trans;
    logic [2:0] level;
    logic [1:0] lives;
  } out_t;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic       start_n = 1'b1, done_n = 1'b1, life_n = 1'b1, pause_n = 1'b1;

  int total = 0;
  int bad   = 0;

  always #10 clk = ~clk;

  sc_statemachine_levelctrl_if #(.LEVEL_WIDTH(3), .LIVES_WIDTH(2)) if0 ();
  sc_statemachine_levelctrl_if #(.LEVEL_WIDTH(3), .LIVES_WIDTH(2)) if1 ();

  assign if0.SC_STATEMACHINE_LEVELCTRL_startButton_InLow = start_n;
  assign if0.SC_STATEMACHINE_LEVELCTRL_levelDone_InLow   = done_n;
  assign if0.SC_STATEMACHINE_LEVELCTRL_lifeLost_InLow    = life_n;
  assign if0.SC_STATEMACHINE_LEVELCTRL_pause_InLow       = pause_n;
  assign if1.SC_STATEMACHINE_LEVELCTRL_startButton_InLow = start_n;
  assign if1.SC_STATEMACHINE_LEVELCTRL_levelDone_InLow   = done_n;
  assign if1.SC_STATEMACHINE_LEVELCTRL_lifeLost_InLow    = life_n;
  assign if1.SC_STATEMACHINE_LEVELCTRL_pause_InLow       = pause_n;

  sc_statemachine_levelctrl #(
    .NUM_LEVELS(NL0), .LEVEL_WIDTH(3), .LIVES(LIVES), .LIVES_WIDTH(2), .TRANS_CYCLES(TC0)
  ) dut0 (
    .SC_STATEMACHINE_LEVELCTRL_CLOCK_50    (clk),
    .SC_STATEMACHINE_LEVELCTRL_RESET_InHigh(rst[0]),
    .bus                                   (if0.slave)
  );

  sc_statemachine_levelctrl #(
    .NUM_LEVELS(NL1), .LEVEL_WIDTH(3), .LIVES(LIVES), .LIVES_WIDTH(2), .TRANS_CYCLES(TC1)
  ) dut1 (
    .SC_STATEMACHINE_LEVELCTRL_CLOCK_50    (clk),
    .SC_STATEMACHINE_LEVELCTRL_RESET_InHigh(rst[1]),
    .bus                                   (if1.slave)
  );

  out_t obs0, obs1;
  assign obs0 = {if0.SC_STATEMACHINE_LEVELCTRL_clear_OutLow, if0.SC_STATEMACHINE_LEVELCTRL_load_OutLow,
                 if0.SC_STATEMACHINE_LEVELCTRL_changeLevel_OutLow, if0.SC_STATEMACHINE_LEVELCTRL_gameOver_OutLow,
                 if0.SC_STATEMACHINE_LEVELCTRL_win_OutLow, if0.SC_STATEMACHINE_LEVELCTRL_transition_OutBUS,
                 if0.SC_STATEMACHINE_LEVELCTRL_level_OutBUS, if0.SC_STATEMACHINE_LEVELCTRL_lives_OutBUS};
  assign obs1 = {if1.SC_STATEMACHINE_LEVELCTRL_clear_OutLow, if1.SC_STATEMACHINE_LEVELCTRL_load_OutLow,
                 if1.SC_STATEMACHINE_LEVELCTRL_changeLevel_OutLow, if1.SC_STATEMACHINE_LEVELCTRL_gameOver_OutLow,
                 if1.SC_STATEMACHINE_LEVELCTRL_win_OutLow, if1.SC_STATEMACHINE_LEVELCTRL_transition_OutBUS,
                 if1.SC_STATEMACHINE_LEVELCTRL_level_OutBUS, if1.SC_STATEMACHINE_LEVELCTRL_lives_OutBUS};

  // ---------------- reference model ----------------
  function automatic mstate_t m_reset();
    mstate_t s;
    s.ph = PH_RST; s.level = 0; s.lives = LIVES; s.left = 0;
    return s;
  endfunction

  // One clock of the game rules.
  function automatic mstate_t m_next(mstate_t s, logic st, logic dn, logic ll, logic pa,
                                     int nl, int tc);
    mstate_t n = s;
    case (s.ph)
      PH_RST:   n.ph = PH_START;
      PH_START: begin n.ph = PH_IDLE; n.lives = LIVES; n.level = 0; end
      PH_IDLE:  if (!st) n.ph = PH_REL;
      PH_REL:   if (st) n.ph = PH_INIT;
      PH_INIT:  begin n.ph = PH_TRANS; n.level = 1; n.left = tc; end
      PH_TRANS: begin n.left = s.left - 1; if (n.left == 0) n.ph = PH_PLAY; end
      PH_PLAY: begin
        if (!dn) begin
          if (s.level < nl) begin n.level = s.level + 1; n.ph = PH_TRANS; n.left = tc; end
          else n.ph = PH_WIN;
        end else if (!ll) begin
          if (s.lives > 1) begin n.lives = s.lives - 1; n.ph = PH_TRANS; n.left = tc; end
          else begin n.lives = 0; n.ph = PH_OVER; end
        end else if (!pa) n.ph = PH_PAUSE;
      end
      PH_PAUSE: if (pa) n.ph = PH_PLAY;
      default:  if (!st) n.ph = PH_START;   // game over or win
    endcase
    return n;
  endfunction

  function automatic out_t m_out(mstate_t s);
    out_t o;
    o.clear_n = (s.ph != PH_INIT);
    o.load_n  = (s.ph != PH_START);
    o.chg_n   = (s.ph != PH_TRANS);
    o.over_n  = (s.ph != PH_OVER);
    o.win_n   = (s.ph != PH_WIN);
    o.trans   = (s.ph == PH_TRANS) ? 3'(s.level) :
                (s.ph == PH_OVER || s.ph == PH_WIN) ? 3'b111 : 3'b000;
    o.level   = 3'(s.level);
    o.lives   = 2'(s.lives);
    return o;
  endfunction

  mstate_t m0, m1;

  // Model update for instance 0.
  always @(posedge clk or posedge rst[0])
    if (rst[0]) m0 <= m_reset();
    else        m0 <= m_next(m0, start_n, done_n, life_n, pause_n, NL0, TC0);

  // Model update for instance 1.
  always @(posedge clk or posedge rst[1])
    if (rst[1]) m1 <= m_reset();
    else        m1 <= m_next(m1, start_n, done_n, life_n, pause_n, NL1, TC1);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock: compare both instances with the model on the falling
  // edge, then return just after it so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    check("cycle dut0", 32'(obs0), 32'(m_out(m0)));
    check("cycle dut1", 32'(obs1), 32'(m_out(m1)));
    #1;
  endtask

  function automatic bit looks_play(out_t o);
    return o.clear_n && o.load_n && o.chg_n && o.over_n && o.win_n &&
           o.trans == 3'd0 && o.level != 3'd0;
  endfunction

  // Bounded wait for instance 1 to be in play.
  task automatic wait_play1();
    bit got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      if (looks_play(obs1)) got = 1'b1;
      else step();
    end
    check("wait_play dut1", 32'(got), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset and power-up.
    step();
    check("rst load", 32'(obs0.load_n), 32'd1);
    check("rst level", 32'(obs0.level), 32'd0);
    check("rst lives", 32'(obs0.lives), 32'd3);
    check("rst trans", 32'(obs0.trans), 32'd0);
    rst = 2'b00;
    step();
    check("start load", 32'(obs0.load_n), 32'd0);
    step();
    check("idle load", 32'(obs0.load_n), 32'd1);
    repeat (3) step();
    check("idle lives", 32'(obs0.lives), 32'd3);
    check("idle level", 32'(obs0.level), 32'd0);

    // Press start for three clocks, then release.
    start_n = 1'b0;
    repeat (3) step();
    start_n = 1'b1;
    step();
    check("init clear", 32'(obs0.clear_n), 32'd0);
    step();
    check("trans chg", 32'(obs0.chg_n), 32'd0);
    check("trans code 1", 32'(obs0.trans), 32'd1);
    step();
    check("play level", 32'(obs0.level), 32'd1);
    check("play chg", 32'(obs0.chg_n), 32'd1);

    // Asynchronous reset of instance 1 in the middle of its transition.
    check("dut1 mid trans", 32'(obs1.chg_n), 32'd0);
    #5 rst[1] = 1'b1;
    #1;
    check("async chg", 32'(obs1.chg_n), 32'd1);
    check("async trans", 32'(obs1.trans), 32'd0);
    check("async level", 32'(obs1.level), 32'd0);
    check("async lives", 32'(obs1.lives), 32'd3);
    step();
    rst[1] = 1'b0;

    // Priority: all three requests together advance the level.
    done_n = 1'b0; life_n = 1'b0; pause_n = 1'b0;
    step();
    done_n = 1'b1; life_n = 1'b1; pause_n = 1'b1;
    check("prio trans", 32'(obs0.trans), 32'd2);
    check("prio level", 32'(obs0.level), 32'd2);
    check("prio lives", 32'(obs0.lives), 32'd3);
    step();

    // Pause holds through level-done and life-lost.
    pause_n = 1'b0;
    step();
    life_n = 1'b0; done_n = 1'b0;
    step();
    life_n = 1'b1; done_n = 1'b1;
    step();
    check("pause lives", 32'(obs0.lives), 32'd3);
    check("pause level", 32'(obs0.level), 32'd2);
    pause_n = 1'b1;
    step();
    check("unpause chg", 32'(obs0.chg_n), 32'd1);

    // Win: levels 3 and 4, then done on the last level.
    done_n = 1'b0; step(); done_n = 1'b1;
    check("win code 3", 32'(obs0.trans), 32'd3);
    step();
    done_n = 1'b0; step(); done_n = 1'b1;
    check("win code 4", 32'(obs0.trans), 32'd4);
    step();
    done_n = 1'b0; step(); done_n = 1'b1;
    check("win flag", 32'(obs0.win_n), 32'd0);
    check("win trans", 32'(obs0.trans), 32'd7);
    check("win level", 32'(obs0.level), 32'd4);
    step();
    check("win hold", 32'(obs0.win_n), 32'd0);

    // Restart with one press and release.
    start_n = 1'b0;
    step();
    check("restart load", 32'(obs0.load_n), 32'd0);
    step();
    check("restart lives", 32'(obs0.lives), 32'd3);
    step();
    start_n = 1'b1;
    repeat (3) step();
    check("replay level", 32'(obs0.level), 32'd1);

    // Game over: three lives lost.
    life_n = 1'b0; step(); life_n = 1'b1;
    check("lost 1 lives", 32'(obs0.lives), 32'd2);
    check("lost 1 code", 32'(obs0.trans), 32'd1);
    step();
    life_n = 1'b0; step(); life_n = 1'b1;
    check("lost 2 lives", 32'(obs0.lives), 32'd1);
    step();
    life_n = 1'b0; step(); life_n = 1'b1;
    check("over flag", 32'(obs0.over_n), 32'd0);
    check("over lives", 32'(obs0.lives), 32'd0);
    check("over trans", 32'(obs0.trans), 32'd7);
    step();
    start_n = 1'b0; repeat (3) step(); start_n = 1'b1;
    repeat (3) step();
    check("over restart lives", 32'(obs0.lives), 32'd3);
    check("over restart level", 32'(obs0.level), 32'd1);

    // Win scenario on the six-level, five-clock-dwell instance.
    rst = 2'b11;
    step();
    rst = 2'b00;
    step();
    start_n = 1'b0;
    repeat (3) step();
    start_n = 1'b1;
    wait_play1();
    for (int lv = 1; lv < NL1; lv++) begin
      done_n = 1'b0; step(); done_n = 1'b1;
      check("dut1 code", 32'(obs1.trans), 32'(lv + 1));
      check("dut1 chg", 32'(obs1.chg_n), 32'd0);
      wait_play1();
    end
    done_n = 1'b0; step(); done_n = 1'b1;
    check("dut1 win", 32'(obs1.win_n), 32'd0);
    check("dut1 win trans", 32'(obs1.trans), 32'd7);
    check("dut1 win level", 32'(obs1.level), 32'd6);

    // Randomized play with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      start_n = ($urandom_range(99) >= 12);
      done_n  = ($urandom_range(99) >= 10);
      life_n  = ($urandom_range(99) >= 10);
      if ($urandom_range(99) < 10) pause_n = ~pause_n;
      if ($urandom_range(399) == 0) begin
        int i = int'($urandom_range(1));
        #3 rst[i] = 1'b1;
        step();
        rst[i] = 1'b0;
      end else begin
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
